// File: rtl/bch_eras_inbuf_pkg.sv
// Shared parameters and types for the BCH erasure decoder input buffer controller.
package bch_eras_inbuf_pkg;

   localparam int cM      = 4;
   localparam int cN      = 15;
   localparam int cBNUM_W = 2;

   typedef logic [cBNUM_W-1:0] ptr_t;
   typedef logic [cM-1:0]      addr_t;

   typedef logic [1:0] fstate_t;
   localparam fstate_t ST_IDLE = 2'd0;
   localparam fstate_t ST_RECV = 2'd1;
   localparam fstate_t ST_DROP = 2'd2;

endpackage

// File: rtl/bch_bank_fifo_ptr.sv
// Bank occupancy tracker: write/read bank pointers and committed-bank count.
module bch_bank_fifo_ptr #(
   parameter int PTR_W = 2
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             clkena_i,
   input  logic             commit_i,
   input  logic             release_i,
   input  logic [PTR_W-1:0] release_ptr_i,
   output logic [PTR_W-1:0] wptr_o,
   output logic [PTR_W:0]   used_o,
   output logic             release_err_o
);

   logic [PTR_W-1:0] wptr_q, wptr_d;
   logic [PTR_W-1:0] rptr_q, rptr_d;
   logic [PTR_W:0]   used_q, used_d;
   logic             relerr_q, relerr_d;
   logic             rel_ok;

   // Releases must retire banks strictly in commit order; anything else is flagged and ignored.
   always_comb begin
      rel_ok   = release_i && (used_q != '0) && (release_ptr_i == rptr_q);
      relerr_d = release_i && !rel_ok;
      wptr_d   = commit_i ? wptr_q + PTR_W'(1) : wptr_q;
      rptr_d   = rel_ok   ? rptr_q + PTR_W'(1) : rptr_q;
      used_d   = used_q;
      if (commit_i && !rel_ok) begin
         used_d = used_q + (PTR_W+1)'(1);
      end else if (!commit_i && rel_ok) begin
         used_d = used_q - (PTR_W+1)'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wptr_q   <= '0;
         rptr_q   <= '0;
         used_q   <= '0;
         relerr_q <= 1'b0;
      end else if (clkena_i) begin
         wptr_q   <= wptr_d;
         rptr_q   <= rptr_d;
         used_q   <= used_d;
         relerr_q <= relerr_d;
      end
   end

   assign wptr_o        = wptr_q;
   assign used_o        = used_q;
   assign release_err_o = relerr_q;

endmodule

// File: rtl/bch_eras_inbuf_ctrl.sv
// Input buffer bank scheduler: frames the sample stream into free banks and
// reports commits, malformed frames and dropped frames.
module bch_eras_inbuf_ctrl
   import bch_eras_inbuf_pkg::*;
#(
   parameter int m       = cM,
   parameter int n       = cN,
   parameter int pBNUM_W = cBNUM_W
) (
   input  logic               iclk,
   input  logic               ireset,
   input  logic               iclkena,
   input  logic               isop,
   input  logic               ival,
   input  logic               ieop,
   output logic               ordy,
   output logic               owrite,
   output logic [m-1:0]       owaddr,
   output logic [pBNUM_W-1:0] owptr,
   output logic               oframe_done,
   output logic [pBNUM_W-1:0] oframe_ptr,
   output logic               oframe_err,
   output logic               odrop,
   input  logic               irelease,
   input  logic [pBNUM_W-1:0] irelease_ptr,
   output logic               orelease_err,
   output logic [pBNUM_W:0]   oused
);

   localparam int               NB        = 1 << pBNUM_W;
   localparam logic [m:0]       CNT_END   = (m+1)'(n);
   localparam logic [m:0]       CNT_LAST  = (m+1)'(n - 1);
   localparam logic [pBNUM_W:0] USED_FULL = (pBNUM_W+1)'(NB);

   fstate_t            state_q, state_d;
   logic [m:0]         cnt_q, cnt_d, idx;
   logic               write_q, write_d;
   logic [m-1:0]       waddr_q, waddr_d;
   logic [pBNUM_W-1:0] wbank_q, wbank_d;
   logic               done_q, done_d;
   logic [pBNUM_W-1:0] fptr_q, fptr_d;
   logic               err_q, err_d;
   logic               drop_q, drop_d;
   logic               commit;
   logic [pBNUM_W-1:0] wptr;
   logic [pBNUM_W:0]   used;

   // An open frame already owns its bank, so it never sees backpressure.
   assign ordy = (state_q == ST_RECV) || (used < USED_FULL);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      write_d = 1'b0;
      waddr_d = waddr_q;
      wbank_d = wbank_q;
      done_d  = 1'b0;
      fptr_d  = fptr_q;
      err_d   = 1'b0;
      drop_d  = 1'b0;
      commit  = 1'b0;
      idx     = (isop || (state_q != ST_RECV)) ? '0 : cnt_q;
      if (ival) begin
         case (state_q)
            ST_IDLE: begin
               if (isop) begin
                  if (ordy) begin
                     write_d = 1'b1;
                     waddr_d = '0;
                     wbank_d = wptr;
                     cnt_d   = (m+1)'(1);
                     if (!ieop) begin
                        state_d = ST_RECV;
                     end else if (CNT_LAST == '0) begin
                        commit = 1'b1;
                     end else begin
                        err_d = 1'b1;
                     end
                  end else begin
                     drop_d = 1'b1;
                     if (!ieop) begin
                        state_d = ST_DROP;
                     end
                  end
               end
            end
            ST_RECV: begin
               // cnt parks at n once the frame overruns, so extra samples are never written.
               if (idx < CNT_END) begin
                  write_d = 1'b1;
                  waddr_d = idx[m-1:0];
                  wbank_d = wptr;
                  cnt_d   = idx + (m+1)'(1);
               end
               if (ieop) begin
                  state_d = ST_IDLE;
                  if (idx == CNT_LAST) begin
                     commit = 1'b1;
                  end else begin
                     err_d = 1'b1;
                  end
               end else if (isop) begin
                  err_d = 1'b1;
               end
            end
            ST_DROP: begin
               if (ieop) begin
                  state_d = ST_IDLE;
               end
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
      if (commit) begin
         done_d = 1'b1;
         fptr_d = wptr;
      end
   end

   always_ff @(posedge iclk or negedge ireset) begin
      if (!ireset) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         write_q <= 1'b0;
         waddr_q <= '0;
         wbank_q <= '0;
         done_q  <= 1'b0;
         fptr_q  <= '0;
         err_q   <= 1'b0;
         drop_q  <= 1'b0;
      end else if (iclkena) begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         write_q <= write_d;
         waddr_q <= waddr_d;
         wbank_q <= wbank_d;
         done_q  <= done_d;
         fptr_q  <= fptr_d;
         err_q   <= err_d;
         drop_q  <= drop_d;
      end
   end

   bch_bank_fifo_ptr #(
      .PTR_W(pBNUM_W)
   ) u_bank_ptr (
      .clk_i        (iclk),
      .rst_ni       (ireset),
      .clkena_i     (iclkena),
      .commit_i     (commit),
      .release_i    (irelease),
      .release_ptr_i(irelease_ptr),
      .wptr_o       (wptr),
      .used_o       (used),
      .release_err_o(orelease_err)
   );

   assign owrite      = write_q;
   assign owaddr      = waddr_q;
   assign owptr       = wbank_q;
   assign oframe_done = done_q;
   assign oframe_ptr  = fptr_q;
   assign oframe_err  = err_q;
   assign odrop       = drop_q;
   assign oused       = used;

endmodule

// File: tb/tb_bch_eras_inbuf_ctrl.sv
// Self-checking bench for bch_eras_inbuf_ctrl: directed scenarios plus a
// randomized run compared against a queue-based bank occupancy model.
module tb_bch_eras_inbuf_ctrl;

   localparam int N  = 15;
   localparam int NB = 4;

   logic       iclk   = 1'b0;
   logic       ireset = 1'b1;
   logic       iclkena, isop, ival, ieop, irelease;
   logic [1:0] irelease_ptr;
   logic       ordy, owrite, oframe_done, oframe_err, odrop, orelease_err;
   logic [3:0] owaddr;
   logic [1:0] owptr, oframe_ptr;
   logic [2:0] oused;

   int vectors     = 0;
   int miscompares = 0;

   // Reference model: committed banks held in order in a queue.
   int bankQ[$];
   int mWbank, mCount;
   bit mInFrame, mDropping;
   bit eWrite, eDone, eErr, eDrop, eRelErr;
   int eAddr, ePtr, eFramePtr;

   always #5 iclk = ~iclk;

   bch_eras_inbuf_ctrl dut (
      .iclk(iclk), .ireset(ireset), .iclkena(iclkena),
      .isop(isop), .ival(ival), .ieop(ieop),
      .ordy(ordy), .owrite(owrite), .owaddr(owaddr), .owptr(owptr),
      .oframe_done(oframe_done), .oframe_ptr(oframe_ptr),
      .oframe_err(oframe_err), .odrop(odrop),
      .irelease(irelease), .irelease_ptr(irelease_ptr),
      .orelease_err(orelease_err), .oused(oused)
   );

   function automatic void modelReset();
      bankQ.delete();
      mWbank = 0; mCount = 0; mInFrame = 0; mDropping = 0;
      eWrite = 0; eDone = 0; eErr = 0; eDrop = 0; eRelErr = 0;
      eAddr = 0; ePtr = 0; eFramePtr = 0;
   endfunction

   function automatic void modelStep();
      bit rdyNow, doCommit, relOk;
      int idx;
      rdyNow   = mInFrame || (bankQ.size() < NB);
      doCommit = 0;
      eWrite = 0; eDone = 0; eErr = 0; eDrop = 0; eRelErr = 0;
      if (ival) begin
         if (mInFrame) begin
            if (isop) mCount = 0;
            idx = mCount;
            if (idx < N) begin eWrite = 1; eAddr = idx; ePtr = mWbank; end
            mCount++;
            if (ieop) begin
               mInFrame = 0;
               if (idx == N - 1) doCommit = 1; else eErr = 1;
            end else if (isop) begin
               eErr = 1;
            end
         end else if (mDropping) begin
            if (ieop) mDropping = 0;
         end else if (isop) begin
            if (rdyNow) begin
               eWrite = 1; eAddr = 0; ePtr = mWbank; mCount = 1;
               if (!ieop) mInFrame = 1;
               else if (N == 1) doCommit = 1;
               else eErr = 1;
            end else begin
               eDrop = 1;
               mDropping = !ieop;
            end
         end
      end
      relOk = irelease && (bankQ.size() > 0) && (int'(irelease_ptr) == bankQ[0]);
      if (relOk) void'(bankQ.pop_front());
      else if (irelease) eRelErr = 1;
      if (doCommit) begin
         eDone = 1; eFramePtr = mWbank;
         bankQ.push_back(mWbank);
         mWbank = (mWbank + 1) % NB;
      end
   endfunction

   task automatic tick();
      @(posedge iclk);
      if (ireset && iclkena) modelStep();
      #1;
   endtask

   task automatic applyStimulus(input bit v, input bit s, input bit e, input bit r, input int rp);
      ival = v; isop = s; ieop = e; irelease = r; irelease_ptr = 2'(rp);
      tick();
   endtask

   task automatic sendFrame(input int len);
      for (int i = 0; i < len; i++) applyStimulus(1, i == 0, i == len - 1, 0, 0);
   endtask

   task automatic test_reset();
      logic [16:0] got;
      #2 ireset = 1'b0;
      #1;
      modelReset();
      got = {ordy, owrite, oframe_done, oframe_err, odrop, orelease_err, oused, owaddr, owptr, oframe_ptr};
      vectors++;
      if (got !== 17'h10000) begin
         $display("[TB] FAIL reset_async outputs got %h want %h", got, 17'h10000); miscompares++;
      end
      applyStimulus(0, 0, 0, 0, 0);
      tick();
      got = {ordy, owrite, oframe_done, oframe_err, odrop, orelease_err, oused, owaddr, owptr, oframe_ptr};
      vectors++;
      if (got !== 17'h10000) begin
         $display("[TB] FAIL reset_held outputs got %h want %h", got, 17'h10000); miscompares++;
      end
      ireset = 1'b1;
      tick();
   endtask

   task automatic test_single_frame();
      for (int i = 0; i < N; i++) begin
         applyStimulus(1, i == 0, i == N - 1, 0, 0);
         vectors++;
         if (owrite !== 1'b1 || owaddr !== 4'(i) || owptr !== 2'd0 || oframe_done !== (i == N - 1)) begin
            $display("[TB] FAIL single_write i=%0d got w=%b a=%0d p=%0d d=%b want 1 %0d 0 %b",
                     i, owrite, owaddr, owptr, oframe_done, i, i == N - 1); miscompares++;
         end
      end
      vectors++;
      if (oframe_ptr !== 2'd0 || oused !== 3'd1 || oframe_err !== 1'b0) begin
         $display("[TB] FAIL single_commit got ptr=%0d used=%0d err=%b want 0 1 0", oframe_ptr, oused, oframe_err);
         miscompares++;
      end
      applyStimulus(0, 0, 0, 0, 0);
      vectors++;
      if (oframe_done !== 1'b0 || owrite !== 1'b0) begin
         $display("[TB] FAIL single_pulse got done=%b write=%b want 0 0", oframe_done, owrite); miscompares++;
      end
   endtask

   task automatic test_back_to_back();
      for (int f = 1; f < NB; f++)
         for (int i = 0; i < N; i++) begin
            applyStimulus(1, i == 0, i == N - 1, 0, 0);
            vectors++;
            if (owrite !== 1'b1 || owptr !== 2'(f) || owaddr !== 4'(i)) begin
               $display("[TB] FAIL b2b_write f=%0d i=%0d got p=%0d a=%0d want %0d %0d", f, i, owptr, owaddr, f, i);
               miscompares++;
            end
         end
      vectors++;
      if (oused !== 3'd4 || ordy !== 1'b0) begin
         $display("[TB] FAIL b2b_full got used=%0d rdy=%b want 4 0", oused, ordy); miscompares++;
      end
      for (int i = 0; i < N; i++) begin
         applyStimulus(1, i == 0, i == N - 1, 0, 0);
         vectors++;
         if (owrite !== 1'b0 || odrop !== (i == 0)) begin
            $display("[TB] FAIL b2b_drop i=%0d got w=%b drop=%b want 0 %b", i, owrite, odrop, i == 0); miscompares++;
         end
      end
      applyStimulus(0, 0, 0, 1, 0);
      vectors++;
      if (oused !== 3'd3 || ordy !== 1'b1 || orelease_err !== 1'b0) begin
         $display("[TB] FAIL b2b_release got used=%0d rdy=%b rerr=%b want 3 1 0", oused, ordy, orelease_err);
         miscompares++;
      end
   endtask

   task automatic test_short_frame();
      for (int i = 0; i < 10; i++) begin
         applyStimulus(1, i == 0, i == 9, 0, 0);
         vectors++;
         if (owptr !== 2'd0 || owaddr !== 4'(i) || oframe_err !== (i == 9) || oframe_done !== 1'b0) begin
            $display("[TB] FAIL short_frame i=%0d got p=%0d a=%0d err=%b done=%b", i, owptr, owaddr, oframe_err, oframe_done);
            miscompares++;
         end
      end
      vectors++;
      if (oused !== 3'd3) begin
         $display("[TB] FAIL short_used got %0d want 3", oused); miscompares++;
      end
      for (int i = 0; i < N; i++) begin
         applyStimulus(1, i == 0, i == N - 1, 0, 0);
         vectors++;
         if (owptr !== 2'd0) begin
            $display("[TB] FAIL short_rewrite_bank i=%0d got %0d want 0", i, owptr); miscompares++;
         end
      end
      vectors++;
      if (oframe_done !== 1'b1 || oframe_ptr !== 2'd0 || oused !== 3'd4) begin
         $display("[TB] FAIL short_recommit got d=%b p=%0d u=%0d want 1 0 4", oframe_done, oframe_ptr, oused);
         miscompares++;
      end
   endtask

   task automatic test_commit_release();
      for (int k = 1; k < NB; k++) applyStimulus(0, 0, 0, 1, k);
      vectors++;
      if (oused !== 3'd1) begin
         $display("[TB] FAIL cr_drain got %0d want 1", oused); miscompares++;
      end
      sendFrame(N);
      for (int i = 0; i < N; i++) applyStimulus(1, i == 0, i == N - 1, i == N - 1, 0);
      vectors++;
      if (oframe_done !== 1'b1 || oframe_ptr !== 2'd2 || oused !== 3'd2 || orelease_err !== 1'b0) begin
         $display("[TB] FAIL cr_same_cycle got d=%b p=%0d u=%0d rerr=%b want 1 2 2 0",
                  oframe_done, oframe_ptr, oused, orelease_err); miscompares++;
      end
      sendFrame(N);
      for (int i = 0; i < N; i++) begin
         applyStimulus(1, i == 0, i == N - 1, 0, 0);
         vectors++;
         if (owptr !== 2'd0) begin
            $display("[TB] FAIL cr_wrap_bank i=%0d got %0d want 0", i, owptr); miscompares++;
         end
      end
      vectors++;
      if (oframe_ptr !== 2'd0 || oused !== 3'd4) begin
         $display("[TB] FAIL cr_wrap_commit got p=%0d u=%0d want 0 4", oframe_ptr, oused); miscompares++;
      end
   endtask

   task automatic test_release_err();
      for (int k = 1; k < NB; k++) applyStimulus(0, 0, 0, 1, k);
      applyStimulus(0, 0, 0, 1, 2);
      vectors++;
      if (orelease_err !== 1'b1 || oused !== 3'd1) begin
         $display("[TB] FAIL rel_out_of_order got rerr=%b u=%0d want 1 1", orelease_err, oused); miscompares++;
      end
      applyStimulus(0, 0, 0, 1, 0);
      vectors++;
      if (orelease_err !== 1'b0 || oused !== 3'd0) begin
         $display("[TB] FAIL rel_valid got rerr=%b u=%0d want 0 0", orelease_err, oused); miscompares++;
      end
      applyStimulus(0, 0, 0, 1, 0);
      vectors++;
      if (orelease_err !== 1'b1 || oused !== 3'd0) begin
         $display("[TB] FAIL rel_empty got rerr=%b u=%0d want 1 0", orelease_err, oused); miscompares++;
      end
      applyStimulus(0, 0, 0, 0, 0);
      vectors++;
      if (orelease_err !== 1'b0) begin
         $display("[TB] FAIL rel_pulse got %b want 0", orelease_err); miscompares++;
      end
   endtask

   task automatic test_reset_mid_frame();
      sendFrame(N);
      for (int i = 0; i < 8; i++) applyStimulus(1, i == 0, 0, 0, 0);
      ireset = 1'b0;
      #1;
      modelReset();
      vectors++;
      if (owrite !== 1'b0 || ordy !== 1'b1 || oused !== 3'd0 || owaddr !== 4'd0) begin
         $display("[TB] FAIL reset_mid got w=%b rdy=%b u=%0d a=%0d want 0 1 0 0", owrite, ordy, oused, owaddr);
         miscompares++;
      end
      applyStimulus(0, 0, 0, 0, 0);
      ireset = 1'b1;
      for (int i = 0; i < N; i++) begin
         applyStimulus(1, i == 0, i == N - 1, 0, 0);
         vectors++;
         if (owptr !== 2'd0 || owaddr !== 4'(i)) begin
            $display("[TB] FAIL reset_resume i=%0d got p=%0d a=%0d want 0 %0d", i, owptr, owaddr, i); miscompares++;
         end
      end
      vectors++;
      if (oframe_done !== 1'b1 || oused !== 3'd1) begin
         $display("[TB] FAIL reset_recommit got d=%b u=%0d want 1 1", oframe_done, oused); miscompares++;
      end
   endtask

   task automatic test_clkena();
      int s = 0;
      for (int c = 0; c < N + 3; c++) begin
         iclkena = !(c >= 6 && c < 9);
         applyStimulus(1, s == 0, s == N - 1, 0, 0);
         vectors++;
         if (iclkena) begin
            if (owrite !== 1'b1 || owaddr !== 4'(s) || owptr !== 2'd1) begin
               $display("[TB] FAIL clkena_write s=%0d got w=%b a=%0d p=%0d want 1 %0d 1", s, owrite, owaddr, owptr, s);
               miscompares++;
            end
            s++;
         end else if (owrite !== 1'b1 || owaddr !== 4'(s - 1)) begin
            $display("[TB] FAIL clkena_hold got w=%b a=%0d want 1 %0d", owrite, owaddr, s - 1); miscompares++;
         end
      end
      iclkena = 1'b1;
      vectors++;
      if (oframe_done !== 1'b1 || oframe_ptr !== 2'd1 || oused !== 3'd2) begin
         $display("[TB] FAIL clkena_commit got d=%b p=%0d u=%0d want 1 1 2", oframe_done, oframe_ptr, oused);
         miscompares++;
      end
   endtask

   task automatic test_random();
      bit genActive = 0;
      int pos = 0, len = N;
      for (int c = 0; c < 3000; c++) begin
         bit v, s, e, r, expRdy;
         int rp;
         iclkena = ($urandom_range(0, 9) != 0);
         v = ($urandom_range(0, 3) != 0);
         if (v && !genActive) begin
            genActive = 1; pos = 0;
            len = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 20)) : N;
         end
         s = v && (pos == 0 || $urandom_range(0, 60) == 0);
         e = v && (pos == len - 1);
         r = ($urandom_range(0, 19) == 0);
         rp = (bankQ.size() > 0 && $urandom_range(0, 4) != 0) ? bankQ[0] : int'($urandom_range(0, 3));
         applyStimulus(v, s, e, r, rp);
         if (iclkena && v) begin
            pos++;
            if (e) genActive = 0;
         end
         expRdy = mInFrame || (bankQ.size() < NB);
         vectors++;
         if (ordy !== expRdy || owrite !== eWrite || oframe_done !== eDone || oframe_err !== eErr ||
             odrop !== eDrop || orelease_err !== eRelErr || oused !== 3'(bankQ.size())) begin
            $display("[TB] FAIL rand_ctrl c=%0d got rdy%b w%b d%b e%b dr%b re%b u%0d want rdy%b w%b d%b e%b dr%b re%b u%0d",
                     c, ordy, owrite, oframe_done, oframe_err, odrop, orelease_err, oused,
                     expRdy, eWrite, eDone, eErr, eDrop, eRelErr, bankQ.size());
            miscompares++;
         end
         if (eWrite) begin
            vectors++;
            if (owaddr !== 4'(eAddr) || owptr !== 2'(ePtr)) begin
               $display("[TB] FAIL rand_waddr c=%0d got a=%0d p=%0d want %0d %0d", c, owaddr, owptr, eAddr, ePtr);
               miscompares++;
            end
         end
         if (eDone) begin
            vectors++;
            if (oframe_ptr !== 2'(eFramePtr)) begin
               $display("[TB] FAIL rand_fptr c=%0d got %0d want %0d", c, oframe_ptr, eFramePtr); miscompares++;
            end
         end
      end
      iclkena = 1'b1;
   endtask

   initial begin
      iclkena = 1'b1; ival = 0; isop = 0; ieop = 0; irelease = 0; irelease_ptr = 0;
      modelReset();
      test_reset();
      test_single_frame();
      test_back_to_back();
      test_short_frame();
      test_commit_release();
      test_release_err();
      test_reset_mid_frame();
      test_clkena();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/bch_eras_inbuf_ctrl.md
Name: bch_eras_inbuf_ctrl

Overview:
Bank scheduler for the 4-bank input buffer of the BCH erasure decoder. Accepts the framed input stream, allocates a free bank per codeword, generates write address/pointer/strobe, and frees banks on release pulses from the downstream decision stage. Applies frame-level backpressure (ordy) when all banks are occupied. Detects malformed frames and reports them.

Parameters:
m, 4, GF(2^m) order; write address width.
n, 15, codeword length in bits (samples per frame).
pBNUM_W, 2, bank pointer width; bank count NB = 2**pBNUM_W.

Ports:
iclk  in  1  clock
ireset  in  1  asynchronous reset, active-low
iclkena  in  1  clock enable; all state holds when low
isop  in  1  frame start, qualified by ival
ival  in  1  sample valid
ieop  in  1  frame end, qualified by ival
ordy  out  1  new frame may start (frame-level backpressure)
owrite  out  1  buffer write strobe
owaddr  out  m  buffer write address, 0..n-1
owptr  out  pBNUM_W  bank being written
oframe_done  out  1  pulse: frame committed to bank oframe_ptr
oframe_ptr  out  pBNUM_W  bank of committed frame
oframe_err  out  1  pulse: frame length error or sop inside frame
odrop  out  1  pulse: frame started while ordy=0, discarded
irelease  in  1  pulse: downstream finished with bank irelease_ptr
irelease_ptr  in  pBNUM_W  bank being released
orelease_err  out  1  pulse: out-of-order or empty release, ignored
oused  out  pBNUM_W+1  committed banks, 0..NB

Behaviour:
- Reset (ireset=0, async): state IDLE; wptr=rptr=0, used=0, cnt=0; ordy=1, all other outputs 0.
- Every transition qualified by iclkena=1.
- FSM IDLE/RECV/DROP:
  - IDLE: ordy = (used<NB). ival&isop with ordy=1 -> RECV, cnt=1, write sample 0. ival&isop with ordy=0 -> DROP, odrop pulse. ival without isop ignored.
  - RECV: ordy=1. Each ival writes at owaddr=cnt, cnt++. ival&isop restarts the frame in the same bank (cnt=1), oframe_err pulse. ival&ieop: if sample index==n-1 -> commit (oframe_done, oframe_ptr=wptr, wptr++ mod NB, used++), else oframe_err and bank not committed; -> IDLE either way. Sample index reaching n-1 without ieop: further samples not written, oframe_err at eop.
  - DROP: ignore samples until ival&ieop -> IDLE. isop&ieop same cycle in IDLE = 1-sample frame: error unless n=1.
- Write path registered: owrite/owaddr/owptr valid 1 cycle after the accepted ival; owptr = wptr at the time of the sample.
- oframe_done, oframe_err, odrop, orelease_err: single-cycle pulses, 1 cycle after the causing sample/release.
- Release: irelease with used>0 and irelease_ptr==rptr -> rptr++ mod NB, used--. Otherwise orelease_err pulse, state unchanged.
- Commit and valid release in same cycle: used unchanged, both pointers advance.
- oused registered, updated with oframe_done; ordy is combinational from registered used and state (no stall cycle after a release).
- Pointer wrap modulo NB; used saturates never (guarded by ordy).
- Reset asserted mid-frame: partial frame abandoned, all banks freed.

Decomposition:
- Shared package (bch parameters): ptr_t (pBNUM_W bits), data_t address type, frame-state enum {IDLE, RECV, DROP}.
- One sub-module natural: bch_bank_fifo_ptr — wptr/rptr/used counter with commit/release/err logic, reusable for the out_buffer 2-bank controller.

Test Plan:
- Single frame n=15: isop at sample 0, ieop at sample 14 -> owaddr 0..14, owptr=0, oframe_done 1 cycle after eop, oused=1, wptr=1.
- Four back-to-back frames, no release -> oused=4, ordy=0; fifth isop -> odrop, no owrite; irelease ptr=0 -> oused=3, ordy=1 same cycle.
- Short frame (ieop at sample 9) -> oframe_err, no oframe_done, oused unchanged, next frame written to same bank.
- Commit and irelease ptr=0 in same cycle with used=2 -> oused stays 2, wptr and rptr both advance; wrap: 5th commit uses bank 0.
- irelease ptr=2 while rptr=0, and irelease with used=0 -> orelease_err each, state unchanged.
- ireset low mid-frame at sample 7 -> all outputs reset immediately, ordy=1, oused=0; iclkena=0 for 3 cycles mid-frame -> addresses resume without gap or duplicate.
